// File: rtl/riscv_test_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | riscv_test_ctrl: runs one core test (reset hold, run, tohost/timeout end)  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module riscv_test_ctrl #(
  parameter int              XLEN           = 32,
  parameter int              RST_CYCLES     = 4,
  parameter int              TIMEOUT_CYCLES = 1000,
  parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(32'h8000_1000),
  parameter int              CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             start,
  input  logic             dmem_we,
  input  logic [XLEN-1:0]  dmem_addr,
  input  logic [XLEN-1:0]  dmem_wdata,
  output logic             core_rstb,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [XLEN-1:0]  exit_code,
  output logic [CNT_W-1:0] cycles
);

  localparam int                c_hold_w    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [c_hold_w-1:0] c_hold_last = c_hold_w'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_timeout   = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_RUN  = 2'd2,
    S_END  = 2'd3
  } state_t;

  state_t              r_state;
  logic [c_hold_w-1:0] r_hold_cnt;
  logic [CNT_W-1:0]    w_cycles_nxt;
  logic                w_hit;

  // Counter saturates so a stuck run never wraps back below the timeout.
  assign w_cycles_nxt = (&cycles) ? cycles : cycles + 1'b1;
  assign w_hit        = dmem_we && (dmem_addr == TOHOST_ADDR) && (dmem_wdata != '0);

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      core_rstb  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      exit_code  <= '0;
      cycles     <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_END: begin
          if (start) begin
            r_state    <= S_HOLD;
            r_hold_cnt <= '0;
            core_rstb  <= 1'b0;
            busy       <= 1'b1;
            done       <= 1'b0;
            pass       <= 1'b0;
            timeout    <= 1'b0;
            exit_code  <= '0;
            cycles     <= '0;
          end
        end
        S_HOLD: begin
          if (r_hold_cnt == c_hold_last) begin
            r_state   <= S_RUN;
            core_rstb <= 1'b1;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end
        S_RUN: begin
          cycles <= w_cycles_nxt;
          // A tohost hit takes priority over a timeout on the same edge.
          if (w_hit) begin
            r_state   <= S_END;
            core_rstb <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= (dmem_wdata == XLEN'(1));
            timeout   <= 1'b0;
            exit_code <= dmem_wdata >> 1;
          end else if (w_cycles_nxt == c_timeout) begin
            r_state   <= S_END;
            core_rstb <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
            timeout   <= 1'b1;
            exit_code <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_riscv_test_ctrl.sv
`default_nettype none
// Directed bench: dut_d uses default parameters, dut_t uses TIMEOUT_CYCLES=20.
module tb_riscv_test_ctrl;
  logic        clk = 1'b0;
  logic        rstb;
  logic        start;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;

  logic        d_core_rstb, d_busy, d_done, d_pass, d_timeout;
  logic [31:0] d_exit, d_cycles;
  logic        t_core_rstb, t_busy, t_done, t_pass, t_timeout;
  logic [31:0] t_exit, t_cycles;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_test_ctrl dut_d (
    .clk(clk), .rstb(rstb), .start(start), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .core_rstb(d_core_rstb), .busy(d_busy), .done(d_done), .pass(d_pass),
    .timeout(d_timeout), .exit_code(d_exit), .cycles(d_cycles)
  );

  riscv_test_ctrl #(.TIMEOUT_CYCLES(20)) dut_t (
    .clk(clk), .rstb(rstb), .start(start), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .core_rstb(t_core_rstb), .busy(t_busy), .done(t_done), .pass(t_pass),
    .timeout(t_timeout), .exit_code(t_exit), .cycles(t_cycles)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    rstb = 1'b0; start = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
    tick(2);
    rstb = 1'b1;
    tick(1);
  endtask

  // Start pulse plus the 4-clock hold; leaves both DUTs just after the RUN entry edge.
  task automatic start_and_hold();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    tick(4);
  endtask

  // Store lands on RUN edge n (counted from the first RUN edge).
  task automatic store_at(input int n, input logic [31:0] addr, input logic [31:0] data);
    if (n > 1) tick(n - 1);
    dmem_we = 1'b1; dmem_addr = addr; dmem_wdata = data;
    tick(1);
    dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
  endtask

  task automatic test_reset();
    rstb = 1'b0; start = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
    #2;
    n_vec++; if ({d_core_rstb, d_busy, d_done, d_pass, d_timeout} !== 5'b0) begin n_err++;
      $display("FAIL reset_flags got=%b exp=00000", {d_core_rstb, d_busy, d_done, d_pass, d_timeout}); end
    n_vec++; if (d_exit !== 32'd0 || d_cycles !== 32'd0) begin n_err++;
      $display("FAIL reset_values exit=%0d cycles=%0d exp=0/0", d_exit, d_cycles); end
    tick(2);
    rstb = 1'b1;
    tick(3);
    n_vec++; if (d_busy !== 1'b0 || d_core_rstb !== 1'b0) begin n_err++;
      $display("FAIL reset_idle busy=%b core_rstb=%b exp=0/0", d_busy, d_core_rstb); end
  endtask

  task automatic test_pass();
    apply_reset();
    start = 1'b1;
    tick(1);
    start = 1'b0;
    n_vec++; if (d_busy !== 1'b1 || d_core_rstb !== 1'b0) begin n_err++;
      $display("FAIL pass_hold_entry busy=%b core_rstb=%b exp=1/0", d_busy, d_core_rstb); end
    for (int i = 0; i < 3; i++) begin
      tick(1);
      n_vec++; if (d_core_rstb !== 1'b0) begin n_err++;
        $display("FAIL pass_hold_%0d core_rstb=%b exp=0", i, d_core_rstb); end
    end
    tick(1);
    n_vec++; if (d_core_rstb !== 1'b1 || d_cycles !== 32'd0) begin n_err++;
      $display("FAIL pass_run_entry core_rstb=%b cycles=%0d exp=1/0", d_core_rstb, d_cycles); end
    tick(9);
    n_vec++; if (d_cycles !== 32'd9 || d_done !== 1'b0) begin n_err++;
      $display("FAIL pass_run9 cycles=%0d done=%b exp=9/0", d_cycles, d_done); end
    store_at(1, 32'h8000_1000, 32'd1);
    n_vec++; if ({d_done, d_pass, d_timeout, d_core_rstb, d_busy} !== 5'b11000) begin n_err++;
      $display("FAIL pass_end_flags got=%b exp=11000", {d_done, d_pass, d_timeout, d_core_rstb, d_busy}); end
    n_vec++; if (d_exit !== 32'd0 || d_cycles !== 32'd10) begin n_err++;
      $display("FAIL pass_end_values exit=%0d cycles=%0d exp=0/10", d_exit, d_cycles); end
    tick(3);
    n_vec++; if (d_done !== 1'b1 || d_pass !== 1'b1 || d_cycles !== 32'd10) begin n_err++;
      $display("FAIL pass_sticky done=%b pass=%b cycles=%0d exp=1/1/10", d_done, d_pass, d_cycles); end
  endtask

  task automatic test_fail();
    apply_reset();
    start_and_hold();
    store_at(5, 32'h8000_1000, 32'd7);
    n_vec++; if ({d_done, d_pass, d_timeout} !== 3'b100) begin n_err++;
      $display("FAIL fail_flags got=%b exp=100", {d_done, d_pass, d_timeout}); end
    n_vec++; if (d_exit !== 32'd3 || d_cycles !== 32'd5) begin n_err++;
      $display("FAIL fail_values exit=%0d cycles=%0d exp=3/5", d_exit, d_cycles); end
  endtask

  // Runs straight on from test_fail, which leaves dut_d in END.
  task automatic test_restart();
    start = 1'b1;
    tick(1);
    n_vec++; if ({d_done, d_pass, d_timeout, d_busy, d_core_rstb} !== 5'b00010) begin n_err++;
      $display("FAIL restart_clear flags=%b exp=00010", {d_done, d_pass, d_timeout, d_busy, d_core_rstb}); end
    n_vec++; if (d_exit !== 32'd0 || d_cycles !== 32'd0) begin n_err++;
      $display("FAIL restart_values exit=%0d cycles=%0d exp=0/0", d_exit, d_cycles); end
    tick(3);
    n_vec++; if (d_core_rstb !== 1'b0) begin n_err++;
      $display("FAIL restart_hold core_rstb=%b exp=0", d_core_rstb); end
    tick(1);
    n_vec++; if (d_core_rstb !== 1'b1) begin n_err++;
      $display("FAIL restart_run core_rstb=%b exp=1", d_core_rstb); end
    tick(5);
    n_vec++; if (d_cycles !== 32'd5 || d_core_rstb !== 1'b1 || d_busy !== 1'b1) begin n_err++;
      $display("FAIL restart_start_held cycles=%0d core_rstb=%b busy=%b exp=5/1/1", d_cycles, d_core_rstb, d_busy); end
    start = 1'b0;
    store_at(1, 32'h8000_1000, 32'd1);
    n_vec++; if (d_done !== 1'b1 || d_pass !== 1'b1 || d_cycles !== 32'd6) begin n_err++;
      $display("FAIL restart_end done=%b pass=%b cycles=%0d exp=1/1/6", d_done, d_pass, d_cycles); end
  endtask

  task automatic test_timeout();
    apply_reset();
    start_and_hold();
    store_at(4, 32'h8000_1004, 32'd1);
    store_at(2, 32'h8000_1000, 32'd0);
    n_vec++; if (t_done !== 1'b0 || t_busy !== 1'b1 || t_cycles !== 32'd6) begin n_err++;
      $display("FAIL timeout_ignored done=%b busy=%b cycles=%0d exp=0/1/6", t_done, t_busy, t_cycles); end
    n_vec++; if (d_done !== 1'b0) begin n_err++;
      $display("FAIL timeout_ignored_d done=%b exp=0", d_done); end
    tick(13);
    n_vec++; if (t_done !== 1'b0 || t_cycles !== 32'd19) begin n_err++;
      $display("FAIL timeout_edge19 done=%b cycles=%0d exp=0/19", t_done, t_cycles); end
    tick(1);
    n_vec++; if ({t_done, t_timeout, t_pass, t_core_rstb, t_busy} !== 5'b11000) begin n_err++;
      $display("FAIL timeout_flags got=%b exp=11000", {t_done, t_timeout, t_pass, t_core_rstb, t_busy}); end
    n_vec++; if (t_exit !== 32'd0 || t_cycles !== 32'd20) begin n_err++;
      $display("FAIL timeout_values exit=%0d cycles=%0d exp=0/20", t_exit, t_cycles); end
    tick(3);
    n_vec++; if (t_cycles !== 32'd20 || t_timeout !== 1'b1) begin n_err++;
      $display("FAIL timeout_sticky cycles=%0d timeout=%b exp=20/1", t_cycles, t_timeout); end
  endtask

  task automatic test_collision();
    apply_reset();
    start_and_hold();
    store_at(20, 32'h8000_1000, 32'd1);
    n_vec++; if ({t_done, t_pass, t_timeout} !== 3'b110) begin n_err++;
      $display("FAIL collision_flags got=%b exp=110", {t_done, t_pass, t_timeout}); end
    n_vec++; if (t_cycles !== 32'd20) begin n_err++;
      $display("FAIL collision_cycles got=%0d exp=20", t_cycles); end
  endtask

  task automatic test_reset_midrun();
    apply_reset();
    start_and_hold();
    tick(5);
    n_vec++; if (d_cycles !== 32'd5 || d_core_rstb !== 1'b1) begin n_err++;
      $display("FAIL midrun_pre cycles=%0d core_rstb=%b exp=5/1", d_cycles, d_core_rstb); end
    rstb = 1'b0;
    #1;
    n_vec++; if ({d_core_rstb, d_busy, d_done, d_pass, d_timeout} !== 5'b0 || d_cycles !== 32'd0 || d_exit !== 32'd0) begin n_err++;
      $display("FAIL midrun_async flags=%b cycles=%0d exit=%0d exp=00000/0/0",
               {d_core_rstb, d_busy, d_done, d_pass, d_timeout}, d_cycles, d_exit); end
    tick(2);
    rstb = 1'b1;
    tick(4);
    n_vec++; if (d_busy !== 1'b0 || d_core_rstb !== 1'b0 || d_cycles !== 32'd0) begin n_err++;
      $display("FAIL midrun_idle busy=%b core_rstb=%b cycles=%0d exp=0/0/0", d_busy, d_core_rstb, d_cycles); end
  endtask

  initial begin
    rstb = 1'b0; start = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_wdata = '0;
    test_reset();
    test_pass();
    test_fail();
    test_restart();
    test_timeout();
    test_collision();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
